// File: rtl/mips_fetch_unit.sv
// Instruction-fetch front end: PC generator, credit-limited request stream
// and prefetch queue delivering {pc, instruction} pairs to decode.
module mips_fetch_unit #(
    parameter int                ADDR_W      = 32,
    parameter int                DATA_W      = 32,
    parameter int                QUEUE_DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_PC    = '0
) (
    input  logic              clk,
    input  logic              reset_n,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_rsp_valid,
    input  logic [DATA_W-1:0] imem_rsp_data,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [DATA_W-1:0] inst_data,
    output logic [ADDR_W-1:0] inst_pc,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc
);

    localparam int CW = $clog2(QUEUE_DEPTH + 1);
    localparam int SW = CW + 1;
    localparam int PW = $clog2(QUEUE_DEPTH);
    localparam logic [SW-1:0] DEPTH = SW'(QUEUE_DEPTH);
    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(4);

    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] rsp_pc;
    logic [CW-1:0]     outstanding;
    logic [CW-1:0]     drop_cnt;
    logic [CW-1:0]     count;
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     wr_ptr;
    logic [ADDR_W-1:0] pc_mem   [QUEUE_DEPTH];
    logic [DATA_W-1:0] data_mem [QUEUE_DEPTH];

    logic [SW-1:0]     credit;
    logic              req_fire;
    logic              rsp_fire;
    logic              rsp_drop;
    logic              push;
    logic              pop;
    logic [ADDR_W-1:0] target_pc;
    logic              unused_lsb;

    assign target_pc  = {redirect_pc[ADDR_W-1:2], 2'b00};
    assign unused_lsb = ^redirect_pc[1:0];

    // Queue slots already promised to in-flight requests count as used.
    assign credit         = {1'b0, count} + {1'b0, outstanding};
    assign imem_req_valid = reset_n && !redirect_valid && (credit < DEPTH);
    assign imem_req_addr  = fetch_pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign rsp_fire = imem_rsp_valid && (outstanding != '0);
    assign rsp_drop = redirect_valid || (drop_cnt != '0);
    assign push     = rsp_fire && !rsp_drop;

    assign inst_valid = (count != '0);
    assign inst_pc    = inst_valid ? pc_mem[rd_ptr] : '0;
    assign inst_data  = inst_valid ? data_mem[rd_ptr] : '0;
    assign pop        = inst_valid && inst_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fetch_pc    <= RESET_PC;
            rsp_pc      <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
            count       <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
        end else begin
            outstanding <= outstanding + CW'(req_fire) - CW'(rsp_fire);
            if (redirect_valid) begin
                fetch_pc <= target_pc;
                rsp_pc   <= target_pc;
                // Everything still in flight is wrong-path, older drops included.
                drop_cnt <= outstanding - CW'(rsp_fire);
                count    <= '0;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
            end else begin
                if (req_fire) begin
                    fetch_pc <= fetch_pc + STEP;
                end
                if (rsp_fire && drop_cnt != '0) begin
                    drop_cnt <= drop_cnt - CW'(1);
                end
                if (push) begin
                    rsp_pc <= rsp_pc + STEP;
                    wr_ptr <= wr_ptr + PW'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PW'(1);
                end
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]   <= rsp_pc;
            data_mem[wr_ptr] <= imem_rsp_data;
        end
    end

    rsp_without_request: assert property (
        @(posedge clk) disable iff (!reset_n)
        imem_rsp_valid |-> (outstanding != '0)
    );

endmodule
